// File: rtl/fmlprobe_pkg.sv
// fmlprobe shared definitions: CSR register indices, capture FSM encoding,
// and the bit layout of the CAP status word.
package fmlprobe_pkg;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STB    = 4'd1;
  localparam logic [3:0] REG_ACK    = 4'd2;
  localparam logic [3:0] REG_WACK   = 4'd3;
  localparam logic [3:0] REG_MAXLAT = 4'd4;
  localparam logic [3:0] REG_FBASE  = 4'd5;
  localparam logic [3:0] REG_FMASK  = 4'd6;
  localparam logic [3:0] REG_CAP    = 4'd7;
  localparam logic [3:0] REG_RADR   = 4'd8;
  localparam logic [3:0] REG_CDO    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cap_state_e;

  // CAP status word: state in [31:30], wrapped flag in [29], wadr from bit 0
  localparam int CAP_ST_HI = 31;
  localparam int CAP_ST_LO = 30;
  localparam int CAP_WRAP  = 29;

endpackage

// File: rtl/fmlprobe_if.sv
// CSR bus plus the observed FML master port. The host/bus side is the master;
// the probe only listens to the FML signals and answers CSR reads.
interface fmlprobe_if #(
  parameter int fml_depth = 26
);
  logic [13:0]          csr_a;
  logic                 csr_we;
  logic [31:0]          csr_di;
  logic [31:0]          csr_do;
  logic                 fml_stb;
  logic                 fml_ack;
  logic                 fml_we;
  logic [fml_depth-1:0] fml_adr;

  modport master (
    output csr_a, csr_we, csr_di, fml_stb, fml_ack, fml_we, fml_adr,
    input  csr_do
  );

  modport slave (
    input  csr_a, csr_we, csr_di, fml_stb, fml_ack, fml_we, fml_adr,
    output csr_do
  );
endinterface

// File: rtl/fmlprobe_ram.sv
// Capture buffer: simple dual-port RAM, one write port, registered read port.
// No reset; contents are meaningless until written.
module fmlprobe_ram #(
  parameter int dw = 27,
  parameter int aw = 12
)(
  input  logic          sys_clk,
  input  logic          we,
  input  logic [aw-1:0] wa,
  input  logic [dw-1:0] wd,
  input  logic [aw-1:0] ra,
  output logic [dw-1:0] rd
);
  logic [dw-1:0] mem [2**aw];

  // write port
  always_ff @(posedge sys_clk)
    if (we) mem[wa] <= wd;

  // registered read port
  always_ff @(posedge sys_clk)
    rd <= mem[ra];
endmodule

// File: rtl/fmlprobe.sv
// fmlprobe: passive FML bus meter. Registers the probed port once, keeps
// saturating traffic counters and worst-case latency, and captures filtered
// acked accesses into a buffer in one-shot or ring mode. CSR-controlled.
module fmlprobe import fmlprobe_pkg::*; #(
  parameter logic [3:0] csr_addr  = 4'h0,
  parameter int         fml_depth = 26,
  parameter int         cap_aw    = 12,
  parameter int         cnt_w     = 32
)(
  input  logic     sys_clk,
  input  logic     sys_rst,
  fmlprobe_if.slave bus
);
  localparam int DW = fml_depth + 1;

  logic                 stb_r, ack_r, we_r;
  logic [fml_depth-1:0] adr_r;

  // probe register stage; everything downstream sees only these copies
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      stb_r <= 1'b0; ack_r <= 1'b0; we_r <= 1'b0; adr_r <= '0;
    end else begin
      stb_r <= bus.fml_stb; ack_r <= bus.fml_ack;
      we_r  <= bus.fml_we;  adr_r <= bus.fml_adr;
    end

  // CSR decode
  logic       csr_sel, wr, rd_cdo, clr, arm, stop;
  logic [3:0] idx;
  assign csr_sel = bus.csr_a[13:10] == csr_addr;
  assign idx     = bus.csr_a[3:0];
  assign wr      = csr_sel & bus.csr_we;
  assign rd_cdo  = csr_sel & ~bus.csr_we & (idx == REG_CDO);
  assign clr     = wr & (idx == REG_CTRL) & bus.csr_di[0];
  assign arm     = wr & (idx == REG_CAP) &  bus.csr_di[0];
  assign stop    = wr & (idx == REG_CAP) & ~bus.csr_di[0];

  logic                 cnt_en, ring;
  logic [fml_depth-1:0] fbase, fmask;
  logic [cap_aw-1:0]    radr;

  // control registers; an explicit RADR write wins over CDO auto-increment
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      cnt_en <= 1'b0; ring <= 1'b0; fbase <= '0; fmask <= '0; radr <= '0;
    end else begin
      if (wr && idx == REG_CTRL)  {ring, cnt_en} <= bus.csr_di[1:0];
      if (wr && idx == REG_FBASE) fbase <= bus.csr_di[fml_depth-1:0];
      if (wr && idx == REG_FMASK) fmask <= bus.csr_di[fml_depth-1:0];
      if (wr && idx == REG_RADR)  radr  <= bus.csr_di[cap_aw-1:0];
      else if (rd_cdo)            radr  <= radr + 1'b1;
    end

  logic [cnt_w-1:0] cnt_stb, cnt_ack, cnt_wack;
  logic [15:0]      maxlat, run, lat;
  assign lat = (run == '1) ? run : run + 16'd1;

  // traffic counters and latency tracker; clear beats a same-cycle increment
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      cnt_stb <= '0; cnt_ack <= '0; cnt_wack <= '0; maxlat <= '0; run <= '0;
    end else if (clr) begin
      cnt_stb <= '0; cnt_ack <= '0; cnt_wack <= '0; maxlat <= '0; run <= '0;
    end else begin
      run <= (stb_r && !ack_r) ? lat : 16'd0;
      if (cnt_en) begin
        if (stb_r && cnt_stb != '1)          cnt_stb  <= cnt_stb + 1'b1;
        if (ack_r && cnt_ack != '1)          cnt_ack  <= cnt_ack + 1'b1;
        if (ack_r && we_r && cnt_wack != '1) cnt_wack <= cnt_wack + 1'b1;
        if (ack_r && lat > maxlat)           maxlat   <= lat;
      end
    end

  cap_state_e        state, state_nx;
  logic [cap_aw-1:0] wadr;
  logic              wrapped, match, cap_we, wlast;

  assign match  = ((adr_r ^ fbase) & fmask) == '0;
  // arm and stop both suppress a capture landing in the same cycle
  assign cap_we = stb_r & ack_r & match & (state == ST_RUN) & ~arm & ~stop;
  assign wlast  = wadr == '1;

  // capture FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_nx;

  // capture FSM next state; re-arming while running restarts the capture
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (arm) state_nx = ST_RUN;
      ST_RUN: begin
        if (arm)                           state_nx = ST_RUN;
        else if (stop)                     state_nx = ST_DONE;
        else if (cap_we && wlast && !ring) state_nx = ST_DONE;
      end
      ST_DONE: if (arm) state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  // capture write pointer; it wraps in both modes, wrapped only flags ring mode
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      wadr <= '0; wrapped <= 1'b0;
    end else if (arm) begin
      wadr <= '0; wrapped <= 1'b0;
    end else if (cap_we) begin
      wadr <= wadr + 1'b1;
      if (wlast && ring) wrapped <= 1'b1;
    end

  logic [DW-1:0] ram_rd;
  fmlprobe_ram #(.dw(DW), .aw(cap_aw)) u_ram (
    .sys_clk (sys_clk),
    .we      (cap_we),
    .wa      (wadr),
    .wd      ({we_r, adr_r}),
    .ra      (radr),
    .rd      (ram_rd)
  );

  logic [31:0] rd_val, cdo_ext, csr_do_q;
  logic        cdo_q;

  // CSR read mux (CDO comes straight from the RAM output register)
  always_comb begin
    rd_val = '0;
    case (idx)
      REG_CTRL:   rd_val[1:0]           = {ring, cnt_en};
      REG_STB:    rd_val[cnt_w-1:0]     = cnt_stb;
      REG_ACK:    rd_val[cnt_w-1:0]     = cnt_ack;
      REG_WACK:   rd_val[cnt_w-1:0]     = cnt_wack;
      REG_MAXLAT: rd_val[15:0]          = maxlat;
      REG_FBASE:  rd_val[fml_depth-1:0] = fbase;
      REG_FMASK:  rd_val[fml_depth-1:0] = fmask;
      REG_CAP: begin
        rd_val[CAP_ST_HI:CAP_ST_LO] = state;
        rd_val[CAP_WRAP]            = wrapped;
        rd_val[cap_aw-1:0]          = wadr;
      end
      REG_RADR:   rd_val[cap_aw-1:0]    = radr;
      default:    rd_val = '0;
    endcase
  end

  // zero-extend capture data to the CSR width
  always_comb begin
    cdo_ext = '0;
    cdo_ext[DW-1:0] = ram_rd;
  end

  // registered CSR read data; zero when the bank is not selected
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      csr_do_q <= '0; cdo_q <= 1'b0;
    end else begin
      csr_do_q <= csr_sel ? rd_val : 32'd0;
      cdo_q    <= csr_sel & (idx == REG_CDO);
    end

  assign bus.csr_do = cdo_q ? cdo_ext : csr_do_q;

endmodule

// File: doc/fmlprobe.md
# fmlprobe

Parametrised FML bus probe: the next-generation bus meter for the FML memory bus. It passively observes one FML master port and keeps saturating traffic counters, the write-ack count and the worst-case access latency. It also keeps an address-filtered capture buffer with one-shot and ring modes. Host software reads and controls it through the CSR bus.

## Interface
- csr_addr, 4'h0, CSR bank select (compared to csr_a[13:10])
- fml_depth, 26, FML address width; must satisfy fml_depth ≤ 31
- cap_aw, 12, capture buffer address width (depth 2^cap_aw)
- cnt_w, 32, traffic counter width (≤ 32)
- sys_clk  in  1  sole clock
- sys_rst  in  1  reset, asynchronous, active-high
- csr_a  in  14  CSR word address
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- fml_stb  in  1  probed strobe
- fml_ack  in  1  probed acknowledge
- fml_we  in  1  probed write flag
- fml_adr  in  fml_depth  probed address

## Operation
- Probe inputs are registered once (the _r copies); all logic uses the _r copies.
- Register map, indexed by csr_a[3:0]:
  - 0 CTRL: bit0 counters_en, bit1 ring mode.
  - 1 STB: cycles with stb_r high.
  - 2 ACK: acks.
  - 3 WACK: acks with we_r high.
  - 4 MAXLAT: 16-bit maximum latency.
  - 5 FBASE: filter base.
  - 6 FMASK: filter mask.
  - 7 CAP: write bit0 = 1 arms, bit0 = 0 stops; read {state[1:0] in [31:30], wrapped in [29], wadr in [cap_aw-1:0]}.
  - 8 RADR: capture read address.
  - 9 CDO: capture data, zero-extended {we, adr}.
  - Indices 10–15 read 0; writes to them are ignored.
- Writing CTRL with bit0 = 1 clears STB, ACK, WACK, MAXLAT and the latency run counter. Writing bit0 = 0 freezes them; they stay readable.
- Counters advance only while counters_en = 1 and saturate at all-ones; they never wrap.
- Latency run counter (16 bit, saturating):
  - Increments each cycle stb_r = 1.
  - On an ack_r cycle, run+1 is compared into MAXLAT and run resets to 0.
  - Resets to 0 when stb_r = 0.
- Filter match: ((adr_r ^ FBASE) & FMASK) == 0. FMASK = 0 matches all addresses.
- A capture event is stb_r & ack_r & match & state == RUN. It writes {we_r, adr_r} at wadr.
- Capture FSM:
  - IDLE → RUN on arm. Arm sets wadr = 0 and wrapped = 0.
  - RUN → DONE on stop.
  - RUN → DONE in one-shot mode after the write at wadr = 2^cap_aw − 1.
  - In ring mode, wadr wraps to 0 and sets wrapped = 1; the FSM stays in RUN.
  - DONE → RUN on arm.
  - Stop in IDLE or DONE has no effect.
- Reading CDO (index 9 selected, csr_we = 0) post-increments RADR modulo 2^cap_aw. This allows burst dumps.

## Timing
- csr_do is valid one cycle after csr_a is presented. csr_do is 0 whenever the bank is not selected.
- Register writes take effect on the clock edge of csr_we.
- Read-after-write of the same register returns the new value from the next access on.
- Capture RAM is simple dual-port with a 1-cycle read. CDO reflects RADR written ≥ 2 cycles earlier.
- Back-to-back CDO reads at one per cycle return consecutive entries.
- Probe-to-counter latency is 2 cycles (probe register plus counter register).
- Simultaneous-event priorities:
  - Counter clear beats increment in the same cycle.
  - Arm beats a same-cycle capture event; that event is not stored.
  - Stop beats a same-cycle capture event; that event is not stored.
  - A write to RADR beats a same-cycle CDO auto-increment.
- Reset values:
  - csr_do = 0, counters_en = 0, ring = 0.
  - All counters = 0, MAXLAT = 0, FBASE = 0, FMASK = 0.
  - state = IDLE, wadr = 0, wrapped = 0, RADR = 0, probe registers = 0.
- Asserting sys_rst mid-capture returns to IDLE immediately. RAM contents are undefined after reset.

## Structure
- fmlprobe_pkg holds:
  - the register index constants 0–9;
  - the FSM state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - the CAP status bit positions.
- Sub-module fmlprobe_ram is a parametrised simple dual-port RAM: one write port, one registered read port, width fml_depth+1, depth 2^cap_aw. It has no reset.
- Top level contains the probe registers, counters, latency tracker, filter, FSM and CSR decode.

## Test plan
- Enable counters, drive 10 transactions each with 3 stall cycles (4 cycles of stb each) → STB = 40, ACK = 10, MAXLAT = 4.
- Set cnt_w = 4 and run 20 acks → ACK reads 15 (saturated). Then write CTRL = 1 while an ack arrives in the same cycle → ACK = 0.
- FBASE = 0x100, FMASK = 0x3FFFF00, arm, drive addresses 0x0FF/0x100/0x1AB/0x200 → capture wadr = 2 with entries 0x100 and 0x1AB.
- One-shot with cap_aw = 3, 9 matching acks → state = DONE, wadr = 0, entries hold acks 1–8. Ring mode, same stimulus → state = RUN, wrapped = 1, entry 0 holds ack 9.
- Arm in the same cycle as a matching ack → that ack is not captured and wadr = 0. Stop in the same cycle as a matching ack → that ack is not captured.
- Write RADR = 0, then 8 consecutive CDO reads → RADR = 0 after wrapping at cap_aw = 3, data in order. Assert sys_rst mid-RUN → state = IDLE and csr_do = 0 immediately.
